out_drain_writer: RTL and testbench



---
 rtl/out_drain_writer_pkg.sv | 34 +++
 rtl/out_lane_convert.sv | 36 +++
 rtl/out_drain_writer.sv | 215 +++++++++++++++++++++
 tb/tb_out_drain_writer.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_drain_writer_pkg.sv
// Shared types and constants for the output drain writer.
// The drain FSM state, the captured FLUSH command and the derived output
// element width live here so the top and the lane converter agree on them.
package out_drain_writer_pkg;

  // Drain sequencing states.
  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StCollect,
    StDone
  } drain_state_e;

  // Command field widths; these track the top-level defaults
  // (TILE_ID_WIDTH = 5, PE_ARRAY_NUM_ROWS = 32 -> 6-bit row count).
  localparam int unsigned CmdIdWidth   = 5;
  localparam int unsigned CmdRowsWidth = 6;

  // One FLUSH command as captured from the controller.
  typedef struct packed {
    logic [CmdIdWidth-1:0]   tile_row;
    logic [CmdIdWidth-1:0]   tile_col;
    logic [CmdIdWidth-1:0]   n_col_tiles;
    logic [CmdRowsWidth-1:0] valid_rows;
  } drain_cmd_t;

  // Output element width: one SRAM row split evenly across the PE lanes.
  function automatic int unsigned calc_out_ew(int unsigned bwidth, int unsigned ncols);
    return bwidth / ncols;
  endfunction

  localparam int unsigned OutEw = calc_out_ew(1024, 32);

endpackage

// File: rtl/out_lane_convert.sv
// Converts one signed accumulator lane to the output element width.
// Build option OUT_DRAIN_SATURATE_EN: when defined, lanes are signed-saturated
// to [-2^(OUT_EW-1), 2^(OUT_EW-1)-1]; otherwise the low OUT_EW bits are kept.
module out_lane_convert
  import out_drain_writer_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = 40,
  parameter int unsigned OUT_EW    = OutEw
) (
  input  logic [ACC_WIDTH-1:0] acc_i,
  output logic [OUT_EW-1:0]    lane_o
);

`ifdef OUT_DRAIN_SATURATE_EN
  // The value fits when every bit above the result sign bit copies it.
  logic fits;
  assign fits = (acc_i[ACC_WIDTH-1:OUT_EW-1] == {(ACC_WIDTH-OUT_EW+1){acc_i[OUT_EW-1]}});

  // Clamp out-of-range values to the nearest representable extreme.
  always_comb begin
    if (fits) begin
      lane_o = acc_i[OUT_EW-1:0];
    end else if (acc_i[ACC_WIDTH-1]) begin
      lane_o = {1'b1, {(OUT_EW-1){1'b0}}};
    end else begin
      lane_o = {1'b0, {(OUT_EW-1){1'b1}}};
    end
  end
`else
  // Upper accumulator bits are intentionally discarded in the truncating build.
  logic unused_hi;
  assign unused_hi = ^acc_i[ACC_WIDTH-1:OUT_EW];
  assign lane_o    = acc_i[OUT_EW-1:0];
`endif

endmodule

// File: rtl/out_drain_writer.sv
// Output drain writer: on FLUSH, shifts a finished tile out of the PE array,
// converts each lane (see out_lane_convert, OUT_DRAIN_SATURATE_EN) and writes
// each tile row to the output SRAM at its row-major address. One further
// command can be queued while a drain is running.
module out_drain_writer
  import out_drain_writer_pkg::*;
#(
  parameter int unsigned PE_ARRAY_NUM_ROWS      = 32,
  parameter int unsigned PE_ARRAY_NUM_COLS      = 32,
  parameter int unsigned ACC_WIDTH              = 40,
  parameter int unsigned OUT_SRAM_AWIDTH        = 10,
  parameter int unsigned OUT_SRAM_BWIDTH        = 1024,
  parameter int unsigned TILE_ID_WIDTH          = 5,
  parameter int unsigned PE_ARRAY_NUM_ROWS_LOG2 = $clog2(PE_ARRAY_NUM_ROWS)
) (
  input  logic                                   CLK,
  input  logic                                   RSTn,
  input  logic                                   FLUSH,
  input  logic [TILE_ID_WIDTH-1:0]               TILE_ROW_ID,
  input  logic [TILE_ID_WIDTH-1:0]               TILE_COL_ID,
  input  logic [TILE_ID_WIDTH-1:0]               N_COL_TILES,
  input  logic [PE_ARRAY_NUM_ROWS_LOG2:0]        VALID_ROWS,
  output logic                                   PE_SHIFT,
  input  logic                                   PE_OUT_VALID,
  input  logic [PE_ARRAY_NUM_COLS*ACC_WIDTH-1:0] PE_OUT_DATA,
  output logic                                   OUT_SRAM_WE,
  output logic [OUT_SRAM_AWIDTH-1:0]             OUT_SRAM_ADDR,
  output logic [OUT_SRAM_BWIDTH-1:0]             OUT_SRAM_WDATA,
  output logic                                   STALL,
  output logic                                   BUSY,
  output logic                                   DRAIN_DONE,
  output logic                                   ERR
);

  localparam int unsigned OUT_EW = calc_out_ew(OUT_SRAM_BWIDTH, PE_ARRAY_NUM_COLS);
  localparam int unsigned RowsW  = PE_ARRAY_NUM_ROWS_LOG2 + 1;
  localparam int unsigned ShiftW = (PE_ARRAY_NUM_ROWS_LOG2 > 0) ? PE_ARRAY_NUM_ROWS_LOG2 : 1;
  localparam logic [RowsW-1:0]  NumRows   = RowsW'(PE_ARRAY_NUM_ROWS);
  localparam logic [ShiftW-1:0] LastShift = ShiftW'(PE_ARRAY_NUM_ROWS - 1);

  drain_state_e                   state_q, state_d;
  drain_cmd_t                     pend_q, pend_d;
  drain_cmd_t                     flush_cmd, load_cmd;
  logic                           pend_valid_q, pend_valid_d;
  logic [ShiftW-1:0]              shift_cnt_q, shift_cnt_d;
  logic [RowsW-1:0]               beat_cnt_q, beat_cnt_d;
  logic [RowsW-1:0]               valid_rows_q, valid_rows_d;
  logic [TILE_ID_WIDTH-1:0]       ncol_q, ncol_d;
  logic [OUT_SRAM_AWIDTH-1:0]     addr_acc_q, addr_acc_d;
  logic                           pe_shift_q, pe_shift_d;
  logic                           we_q, we_d;
  logic [OUT_SRAM_AWIDTH-1:0]     addr_q, addr_d;
  logic [OUT_SRAM_BWIDTH-1:0]     wdata_q, wdata_d;
  logic                           busy_q, busy_d;
  logic                           drain_done_q, drain_done_d;
  logic                           err_q, err_d;
  logic                           beat_fire;
  logic                           do_load;
  logic [PE_ARRAY_NUM_COLS*OUT_EW-1:0] lane_out;

  // Address of tile row 0; the only multiply, used once per command load.
  function automatic logic [OUT_SRAM_AWIDTH-1:0] cmd_base(drain_cmd_t c);
    logic [31:0] full;
    full = 32'(c.tile_row) * 32'(PE_ARRAY_NUM_ROWS) * 32'(c.n_col_tiles) + 32'(c.tile_col);
    return full[OUT_SRAM_AWIDTH-1:0];
  endfunction

  assign flush_cmd = '{
    tile_row:    CmdIdWidth'(TILE_ROW_ID),
    tile_col:    CmdIdWidth'(TILE_COL_ID),
    n_col_tiles: CmdIdWidth'(N_COL_TILES),
    valid_rows:  CmdRowsWidth'(VALID_ROWS)
  };

  for (genvar c = 0; c < PE_ARRAY_NUM_COLS; c++) begin : g_lane
    out_lane_convert #(
      .ACC_WIDTH(ACC_WIDTH),
      .OUT_EW   (OUT_EW)
    ) u_lane_convert (
      .acc_i (PE_OUT_DATA[c*ACC_WIDTH +: ACC_WIDTH]),
      .lane_o(lane_out[c*OUT_EW +: OUT_EW])
    );
  end

  // Next-state logic: beat accounting, command queueing and drain sequencing.
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    shift_cnt_d  = shift_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    valid_rows_d = valid_rows_q;
    ncol_d       = ncol_q;
    addr_acc_d   = addr_acc_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    do_load      = 1'b0;
    load_cmd     = flush_cmd;

    // Every beat advances the row address; rows past VALID_ROWS are not written.
    beat_fire = PE_OUT_VALID && ((state_q == StShift) || (state_q == StCollect));
    if (beat_fire) begin
      beat_cnt_d = beat_cnt_q + RowsW'(1);
      addr_acc_d = addr_acc_q + OUT_SRAM_AWIDTH'(ncol_q);
      if (beat_cnt_q < valid_rows_q) begin
        we_d    = 1'b1;
        addr_d  = addr_acc_q;
        wdata_d = OUT_SRAM_BWIDTH'(lane_out);
      end
    end

    // A FLUSH that finds the pending slot full is dropped.
    if (FLUSH && pend_valid_q) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (FLUSH) do_load = 1'b1;
      end
      StShift: begin
        if (FLUSH && !pend_valid_q) begin
          pend_d       = flush_cmd;
          pend_valid_d = 1'b1;
        end
        shift_cnt_d = shift_cnt_q + ShiftW'(1);
        if (shift_cnt_q == LastShift) begin
          state_d = (beat_cnt_d == NumRows) ? StDone : StCollect;
        end
      end
      StCollect: begin
        if (FLUSH && !pend_valid_q) begin
          pend_d       = flush_cmd;
          pend_valid_d = 1'b1;
        end
        if (beat_cnt_d == NumRows) state_d = StDone;
      end
      StDone: begin
        // Queued work wins; otherwise a same-cycle FLUSH starts without an idle gap.
        if (pend_valid_q) begin
          do_load      = 1'b1;
          load_cmd     = pend_q;
          pend_valid_d = 1'b0;
        end else if (FLUSH) begin
          do_load = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (do_load) begin
      state_d      = StShift;
      shift_cnt_d  = '0;
      beat_cnt_d   = '0;
      addr_acc_d   = cmd_base(load_cmd);
      ncol_d       = TILE_ID_WIDTH'(load_cmd.n_col_tiles);
      valid_rows_d = RowsW'(load_cmd.valid_rows);
    end

    pe_shift_d   = (state_d == StShift);
    busy_d       = (state_d != StIdle);
    drain_done_d = (state_d == StDone);
  end

  // State and registered outputs; reset aborts any drain in progress.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q      <= StIdle;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      shift_cnt_q  <= '0;
      beat_cnt_q   <= '0;
      valid_rows_q <= '0;
      ncol_q       <= '0;
      addr_acc_q   <= '0;
      pe_shift_q   <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      busy_q       <= 1'b0;
      drain_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      shift_cnt_q  <= shift_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      valid_rows_q <= valid_rows_d;
      ncol_q       <= ncol_d;
      addr_acc_q   <= addr_acc_d;
      pe_shift_q   <= pe_shift_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      busy_q       <= busy_d;
      drain_done_q <= drain_done_d;
      err_q        <= err_d;
    end
  end

  assign PE_SHIFT       = pe_shift_q;
  assign OUT_SRAM_WE    = we_q;
  assign OUT_SRAM_ADDR  = addr_q;
  assign OUT_SRAM_WDATA = wdata_q;
  assign STALL          = pend_valid_q;
  assign BUSY           = busy_q;
  assign DRAIN_DONE     = drain_done_q;
  assign ERR            = err_q;

endmodule

// File: tb/tb_out_drain_writer.sv
// Self-checking bench for out_drain_writer: random lane data and gaps, with
// expected writes derived from the address formula and lane-conversion rules.
module tb_out_drain_writer;

  localparam int Rows = 32;
  localparam int Cols = 32;
  localparam int AccW = 40;
  localparam int AW   = 10;
  localparam int BW   = 1024;
  localparam int IdW  = 5;
  localparam int Ew   = 32;
  localparam longint SatMax = (longint'(1) <<< 31) - 1;
  localparam longint SatMin = -(longint'(1) <<< 31);

  logic                 CLK = 1'b0;
  logic                 RSTn = 1'b0;
  logic                 FLUSH = 1'b0;
  logic [IdW-1:0]       TILE_ROW_ID = '0;
  logic [IdW-1:0]       TILE_COL_ID = '0;
  logic [IdW-1:0]       N_COL_TILES = '0;
  logic [5:0]           VALID_ROWS = '0;
  logic                 PE_SHIFT;
  logic                 PE_OUT_VALID = 1'b0;
  logic [Cols*AccW-1:0] PE_OUT_DATA = '0;
  logic                 OUT_SRAM_WE;
  logic [AW-1:0]        OUT_SRAM_ADDR;
  logic [BW-1:0]        OUT_SRAM_WDATA;
  logic                 STALL;
  logic                 BUSY;
  logic                 DRAIN_DONE;
  logic                 ERR;

  out_drain_writer dut (
    .CLK           (CLK),
    .RSTn          (RSTn),
    .FLUSH         (FLUSH),
    .TILE_ROW_ID   (TILE_ROW_ID),
    .TILE_COL_ID   (TILE_COL_ID),
    .N_COL_TILES   (N_COL_TILES),
    .VALID_ROWS    (VALID_ROWS),
    .PE_SHIFT      (PE_SHIFT),
    .PE_OUT_VALID  (PE_OUT_VALID),
    .PE_OUT_DATA   (PE_OUT_DATA),
    .OUT_SRAM_WE   (OUT_SRAM_WE),
    .OUT_SRAM_ADDR (OUT_SRAM_ADDR),
    .OUT_SRAM_WDATA(OUT_SRAM_WDATA),
    .STALL         (STALL),
    .BUSY          (BUSY),
    .DRAIN_DONE    (DRAIN_DONE),
    .ERR           (ERR)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int flush_cyc;
  int last_beat_cyc;

  always @(posedge CLK) cyc <= cyc + 1;

  // Observed activity, sampled mid-cycle.
  logic [AW-1:0] got_addr[$];
  logic [BW-1:0] got_data[$];
  int            got_cyc[$];
  int            shift_n, first_shift, last_shift, done_n, done_cyc;

  // Expected writes from the reference model.
  logic [AW-1:0] exp_addr[$];
  logic [BW-1:0] exp_data[$];
  int            exp_cyc[$];

  always @(negedge CLK) begin
    if (OUT_SRAM_WE) begin
      got_addr.push_back(OUT_SRAM_ADDR);
      got_data.push_back(OUT_SRAM_WDATA);
      got_cyc.push_back(cyc);
    end
    if (PE_SHIFT) begin
      if (shift_n == 0) first_shift = cyc;
      last_shift = cyc;
      shift_n++;
    end
    if (DRAIN_DONE) begin
      done_n++;
      done_cyc = cyc;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [Ew-1:0] ref_conv(logic [AccW-1:0] raw);
    longint v;
    v = $signed({{(64-AccW){raw[AccW-1]}}, raw});
`ifdef OUT_DRAIN_SATURATE_EN
    if (v > SatMax) return SatMax[Ew-1:0];
    if (v < SatMin) return SatMin[Ew-1:0];
`endif
    return v[Ew-1:0];
  endfunction

  function automatic logic [BW-1:0] ref_row(logic [Cols*AccW-1:0] d);
    logic [BW-1:0] r;
    for (int c = 0; c < Cols; c++) r[c*Ew +: Ew] = ref_conv(d[c*AccW +: AccW]);
    return r;
  endfunction

  function automatic logic [AW-1:0] ref_addr(int row, int col, int ncol, int k);
    int a;
    a = ((row * Rows + k) * ncol + col) % (1 << AW);
    return a[AW-1:0];
  endfunction

  function automatic logic [AccW-1:0] rand_lane();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0:       return {{(AccW-32){r[31]}}, r[31:0]};
      1:       return {1'b0, r[AccW-2:0]};
      2:       return {1'b1, r[AccW-2:0]};
      default: return r[AccW-1:0];
    endcase
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_all();
    got_addr.delete(); got_data.delete(); got_cyc.delete();
    exp_addr.delete(); exp_data.delete(); exp_cyc.delete();
    shift_n = 0; first_shift = -1; last_shift = -1; done_n = 0; done_cyc = -1;
  endtask

  task automatic flush_cmd(input int row, input int col, input int ncol, input int vr);
    FLUSH       = 1'b1;
    TILE_ROW_ID = IdW'(row);
    TILE_COL_ID = IdW'(col);
    N_COL_TILES = IdW'(ncol);
    VALID_ROWS  = 6'(vr);
    flush_cyc   = cyc;
    tick();
    FLUSH = 1'b0;
  endtask

  // Drives beats k0..k1-1 of a tile and records the writes they should cause.
  task automatic run_beats(input int lead, input int k0, input int k1, input int row,
                           input int col, input int ncol, input int vr, input bit gaps,
                           input bit special);
    logic [Cols*AccW-1:0] d;
    repeat (lead) tick();
    for (int k = k0; k < k1; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      for (int c = 0; c < Cols; c++) d[c*AccW +: AccW] = rand_lane();
      if (special && k == 0) begin
        d[0*AccW +: AccW] = 40'h7F_FFFF_FFFF;
        d[1*AccW +: AccW] = 40'hFF_FFFF_FFFF;
        d[2*AccW +: AccW] = 40'h80_0000_0000;
        d[3*AccW +: AccW] = 40'h00_8000_0000;
      end
      PE_OUT_DATA  = d;
      PE_OUT_VALID = 1'b1;
      if (k < vr) begin
        exp_addr.push_back(ref_addr(row, col, ncol, k));
        exp_data.push_back(ref_row(d));
        exp_cyc.push_back(cyc + 1);
      end
      last_beat_cyc = cyc;
      tick();
      PE_OUT_VALID = 1'b0;
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({PE_SHIFT, OUT_SRAM_WE, STALL, BUSY, DRAIN_DONE, ERR} !== 6'b0) begin
      $display("FAIL reset_flags: got %b, want 000000",
               {PE_SHIFT, OUT_SRAM_WE, STALL, BUSY, DRAIN_DONE, ERR});
    end else n_pass++;
    n_checks++;
    if (OUT_SRAM_ADDR !== '0) $display("FAIL reset_addr: got %0d, want 0", OUT_SRAM_ADDR);
    else n_pass++;
    n_checks++;
    if (OUT_SRAM_WDATA !== '0) $display("FAIL reset_wdata: got nonzero, want 0");
    else n_pass++;
  endtask

  task automatic test_basic();
    clear_all();
    flush_cmd(1, 2, 3, 32);
    run_beats(1, 0, 32, 1, 2, 3, 32, 1'b0, 1'b0);
    repeat (3) tick();
    n_checks++;
    if (got_addr.size() !== 32) $display("FAIL basic_count: got %0d, want 32", got_addr.size());
    else n_pass++;
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      n_checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] || got_cyc[i] !== exp_cyc[i])
        $display("FAIL basic_write[%0d]: addr %0d want %0d, cyc %0d want %0d, lane0 %h want %h",
                 i, got_addr[i], exp_addr[i], got_cyc[i], exp_cyc[i], got_data[i][31:0],
                 exp_data[i][31:0]);
      else n_pass++;
    end
    n_checks++;
    if (got_addr.size() != 32 || got_addr[0] !== 10'd98 || got_addr[31] !== 10'd191)
      $display("FAIL basic_endpoints: first/last addr wrong, want 98 and 191");
    else n_pass++;
    n_checks++;
    if (shift_n !== 32 || first_shift !== flush_cyc + 1 || last_shift !== flush_cyc + 32)
      $display("FAIL basic_shift: %0d cycles from %0d to %0d, want 32 from %0d", shift_n,
               first_shift, last_shift, flush_cyc + 1);
    else n_pass++;
    n_checks++;
    if (done_n !== 1 || done_cyc !== last_beat_cyc + 1)
      $display("FAIL basic_done: %0d pulses at %0d, want 1 at %0d", done_n, done_cyc,
               last_beat_cyc + 1);
    else n_pass++;
    n_checks++;
    if (BUSY !== 1'b0) $display("FAIL basic_idle_busy: got %b, want 0", BUSY);
    else n_pass++;
  endtask

  task automatic test_edge_tile();
    int row, col, ncol;
    clear_all();
    row = $urandom_range(0, 31); col = $urandom_range(0, 31); ncol = $urandom_range(1, 31);
    flush_cmd(row, col, ncol, 5);
    run_beats(1, 0, 32, row, col, ncol, 5, 1'b1, 1'b0);
    repeat (3) tick();
    n_checks++;
    if (got_addr.size() !== 5) $display("FAIL edge_count: got %0d, want 5", got_addr.size());
    else n_pass++;
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      n_checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] || got_cyc[i] !== exp_cyc[i])
        $display("FAIL edge_write[%0d]: addr %0d want %0d, cyc %0d want %0d", i, got_addr[i],
                 exp_addr[i], got_cyc[i], exp_cyc[i]);
      else n_pass++;
    end
    n_checks++;
    if (done_n !== 1 || done_cyc !== last_beat_cyc + 1)
      $display("FAIL edge_done: %0d pulses at %0d, want 1 at %0d", done_n, done_cyc,
               last_beat_cyc + 1);
    else n_pass++;
  endtask

  task automatic test_queueing();
    int ar, ac, an, br, bc, bn, bv, a_last;
    clear_all();
    ar = $urandom_range(0, 31); ac = $urandom_range(0, 31); an = $urandom_range(1, 31);
    br = $urandom_range(0, 31); bc = $urandom_range(0, 31); bn = $urandom_range(1, 31);
    bv = $urandom_range(1, 32);
    flush_cmd(ar, ac, an, 32);
    run_beats(1, 0, 3, ar, ac, an, 32, 1'b0, 1'b0);
    flush_cmd(br, bc, bn, bv);
    n_checks++;
    if (STALL !== 1'b1 || ERR !== 1'b0)
      $display("FAIL queue_stall: STALL %b ERR %b, want 1 0", STALL, ERR);
    else n_pass++;
    flush_cmd(7, 7, 7, 32);
    n_checks++;
    if (ERR !== 1'b1 || STALL !== 1'b1)
      $display("FAIL queue_err: ERR %b STALL %b, want 1 1", ERR, STALL);
    else n_pass++;
    run_beats(0, 3, 32, ar, ac, an, 32, 1'b1, 1'b0);
    a_last = last_beat_cyc;
    shift_n = 0;
    run_beats(2, 0, 32, br, bc, bn, bv, 1'b1, 1'b0);
    repeat (3) tick();
    n_checks++;
    if (got_addr.size() !== 32 + bv)
      $display("FAIL queue_count: got %0d, want %0d", got_addr.size(), 32 + bv);
    else n_pass++;
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      n_checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] || got_cyc[i] !== exp_cyc[i])
        $display("FAIL queue_write[%0d]: addr %0d want %0d, cyc %0d want %0d", i, got_addr[i],
                 exp_addr[i], got_cyc[i], exp_cyc[i]);
      else n_pass++;
    end
    n_checks++;
    if (first_shift !== a_last + 2 || shift_n !== 32)
      $display("FAIL queue_second_start: shift from %0d for %0d, want from %0d for 32",
               first_shift, shift_n, a_last + 2);
    else n_pass++;
    n_checks++;
    if (done_n !== 2 || STALL !== 1'b0 || ERR !== 1'b1)
      $display("FAIL queue_end: done %0d STALL %b ERR %b, want 2 0 1", done_n, STALL, ERR);
    else n_pass++;
  endtask

  task automatic test_lane_convert();
    logic [Ew-1:0] want0, want2, want3;
    clear_all();
`ifdef OUT_DRAIN_SATURATE_EN
    want0 = 32'h7FFF_FFFF; want2 = 32'h8000_0000; want3 = 32'h7FFF_FFFF;
`else
    want0 = 32'hFFFF_FFFF; want2 = 32'h0000_0000; want3 = 32'h8000_0000;
`endif
    flush_cmd(0, 0, 1, 1);
    run_beats(1, 0, 32, 0, 0, 1, 1, 1'b0, 1'b1);
    repeat (3) tick();
    n_checks++;
    if (got_data.size() !== 1) $display("FAIL lane_count: got %0d, want 1", got_data.size());
    else n_pass++;
    if (got_data.size() > 0) begin
      n_checks++;
      if (got_data[0][31:0] !== want0 || got_data[0][63:32] !== 32'hFFFF_FFFF)
        $display("FAIL lane_max_minus1: got %h %h, want %h ffffffff", got_data[0][31:0],
                 got_data[0][63:32], want0);
      else n_pass++;
      n_checks++;
      if (got_data[0][95:64] !== want2 || got_data[0][127:96] !== want3)
        $display("FAIL lane_extremes: got %h %h, want %h %h", got_data[0][95:64],
                 got_data[0][127:96], want2, want3);
      else n_pass++;
      n_checks++;
      if (got_data[0] !== exp_data[0] || got_addr[0] !== 10'd0)
        $display("FAIL lane_row: addr %0d want 0, lane4 %h want %h", got_addr[0],
                 got_data[0][159:128], exp_data[0][159:128]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_drain();
    int row, col, ncol;
    clear_all();
    row = $urandom_range(0, 31); col = $urandom_range(0, 31); ncol = $urandom_range(1, 31);
    flush_cmd(row, col, ncol, 32);
    run_beats(1, 0, 10, row, col, ncol, 32, 1'b0, 1'b0);
    tick();
    RSTn = 1'b0;
    #1;
    n_checks++;
    if ({PE_SHIFT, OUT_SRAM_WE, STALL, BUSY, DRAIN_DONE, ERR} !== 6'b0 ||
        OUT_SRAM_ADDR !== '0 || OUT_SRAM_WDATA !== '0)
      $display("FAIL rst_mid_outputs: flags %b addr %0d, want all zero",
               {PE_SHIFT, OUT_SRAM_WE, STALL, BUSY, DRAIN_DONE, ERR}, OUT_SRAM_ADDR);
    else n_pass++;
    PE_OUT_VALID = 1'b1;
    repeat (3) tick();
    RSTn = 1'b1;
    repeat (3) tick();
    PE_OUT_VALID = 1'b0;
    tick();
    n_checks++;
    if (got_addr.size() !== 10) $display("FAIL rst_mid_count: got %0d, want 10", got_addr.size());
    else n_pass++;
    n_checks++;
    if ({PE_SHIFT, OUT_SRAM_WE, BUSY, DRAIN_DONE, ERR} !== 5'b0 || done_n !== 0)
      $display("FAIL rst_mid_quiet: flags %b done %0d, want zero",
               {PE_SHIFT, OUT_SRAM_WE, BUSY, DRAIN_DONE, ERR}, done_n);
    else n_pass++;
    clear_all();
    row = $urandom_range(0, 31); col = $urandom_range(0, 31); ncol = $urandom_range(1, 31);
    flush_cmd(row, col, ncol, 32);
    run_beats(1, 0, 32, row, col, ncol, 32, 1'b1, 1'b0);
    repeat (3) tick();
    n_checks++;
    if (got_addr.size() !== 32 || done_n !== 1)
      $display("FAIL rst_after_count: got %0d writes %0d done, want 32 1", got_addr.size(), done_n);
    else n_pass++;
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      n_checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i])
        $display("FAIL rst_after_write[%0d]: addr %0d want %0d", i, got_addr[i], exp_addr[i]);
      else n_pass++;
    end
  endtask

  task automatic test_addr_wrap();
    int rows_tbl[2] = '{31, 20};
    for (int t = 0; t < 2; t++) begin
      int col;
      clear_all();
      col = $urandom_range(0, 31);
      flush_cmd(rows_tbl[t], col, 31, 32);
      run_beats(1, 0, 32, rows_tbl[t], col, 31, 32, 1'b1, 1'b0);
      repeat (3) tick();
      n_checks++;
      if (got_addr.size() !== 32) $display("FAIL wrap_count: got %0d, want 32", got_addr.size());
      else n_pass++;
      for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
        n_checks++;
        if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i])
          $display("FAIL wrap_write[%0d]: addr %0d want %0d", i, got_addr[i], exp_addr[i]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    clear_all();
    repeat (3) tick();
    test_reset();
    RSTn = 1'b1;
    repeat (2) tick();
    test_reset();
    test_basic();
    test_edge_tile();
    test_queueing();
    test_lane_convert();
    test_reset_mid_drain();
    test_addr_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
